serial_or_deserializer: RTL and testbench

- Sequential front-end for the OR-gate exercises.
- Accepts two synchronous serial bit streams `a` and `b`, LSB first, under a valid/ready handshake.
- Each bit pair is ORed, and the results are accumulated into a WIDTH-bit word.
- Each completed word is presented downstream with a valid/ready handshake, plus a reduction flag and a word counter.

---
 rtl/serial_or_deserializer.sv | 104 ++++++++++
 tb/tb_serial_or_deserializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_or_deserializer.sv
// Two serial bit streams go in LSB first. Each bit pair is ORed and the results are packed into WIDTH-bit words.
// Each finished word is handed downstream under valid/ready, with a reduction flag and a hand-off counter.
module serial_or_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             up_valid,
  output logic             up_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_any,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [IDX_W-1:0]   r_bitIdx;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_downData;
  logic               r_downAny;
  logic [CNT_W-1:0]   r_wordCnt;

  logic               w_upReady;
  logic               w_accept;
  logic               w_last;
  logic               w_handoff;
  logic               w_bit;
  logic [WIDTH-1:0]   w_bitMask;
  logic [WIDTH-1:0]   w_word;

  // Input stalls only while a finished word waits unaccepted; down_ready is the sole combinational path.
  assign w_upReady = (r_state == COLLECT) | down_ready;
  assign w_accept  = up_valid & w_upReady;
  assign w_last    = w_accept & (r_bitIdx == LAST_IDX);
  assign w_handoff = (r_state == HOLD) & down_ready;
  assign w_bit     = a | b;
  assign w_bitMask = {{(WIDTH-1){1'b0}}, 1'b1} << r_bitIdx;
  assign w_word    = w_bit ? (r_shift | w_bitMask) : r_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      COLLECT: if (w_last) w_nextState = HOLD;
      HOLD:    if (down_ready && !w_last) w_nextState = COLLECT;
      default: w_nextState = COLLECT;
    endcase
  end

  // The shift register is cleared on completion, so the next word starts from all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_downData <= '0;
      r_downAny  <= 1'b0;
      r_wordCnt  <= '0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_bitIdx <= '0;
          r_shift  <= '0;
        end else begin
          r_bitIdx <= r_bitIdx + IDX_W'(1);
          r_shift  <= w_word;
        end
      end
      if (w_last) begin
        r_downData <= w_word;
        r_downAny  <= |w_word;
      end
      if (w_handoff) begin
        r_wordCnt <= r_wordCnt + CNT_W'(1);
      end
    end
  end

  assign up_ready   = w_upReady;
  assign down_data  = r_downData;
  assign down_any   = r_downAny;
  assign down_valid = (r_state == HOLD);
  assign word_cnt   = r_wordCnt;

endmodule

// File: tb/tb_serial_or_deserializer.sv
// Directed bench for serial_or_deserializer. Expected values are hand-computed.
// A second instance with a 2-bit counter shares all inputs so that counter wrap can be observed.
module tb_serial_or_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       up_valid = 1'b0;
  logic       down_ready = 1'b1;
  logic       up_ready;
  logic [3:0] down_data;
  logic       down_any;
  logic       down_valid;
  logic [7:0] word_cnt;

  logic       nUpReady;
  logic [3:0] nDownData;
  logic       nDownAny;
  logic       nDownValid;
  logic [1:0] nWordCnt;

  int testsRun = 0;
  int testsFailed = 0;

  serial_or_deserializer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .up_valid(up_valid), .up_ready(up_ready),
    .down_data(down_data), .down_any(down_any), .down_valid(down_valid),
    .down_ready(down_ready), .word_cnt(word_cnt)
  );

  serial_or_deserializer #(.WIDTH(4), .CNT_W(2)) dutNarrow (
    .clk(clk), .rst(rst), .a(a), .b(b), .up_valid(up_valid), .up_ready(nUpReady),
    .down_data(nDownData), .down_any(nDownAny), .down_valid(nDownValid),
    .down_ready(down_ready), .word_cnt(nWordCnt)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench funnels through this task so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of upstream inputs and returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic valid, input logic aBit, input logic bBit);
    up_valid = valid;
    a = aBit;
    b = bBit;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    a = 1'bx;
    b = 1'bx;
  endtask

  task automatic sendWord(input logic [3:0] aWord, input logic [3:0] bWord);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, aWord[i], bWord[i]);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  logic [1:0] wrapExpect [5];

  initial begin
    wrapExpect[0] = 2'd1;
    wrapExpect[1] = 2'd2;
    wrapExpect[2] = 2'd3;
    wrapExpect[3] = 2'd0;
    wrapExpect[4] = 2'd1;

    // Reset state
    down_ready = 1'b1;
    doReset();
    checkOutput("rst_valid", 32'(down_valid), 32'd0);
    checkOutput("rst_data", 32'(down_data), 32'd0);
    checkOutput("rst_any", 32'(down_any), 32'd0);
    checkOutput("rst_cnt", 32'(word_cnt), 32'd0);
    checkOutput("rst_upready", 32'(up_ready), 32'd1);

    // Basic word: a=1,0,0,0 b=0,0,1,0 gives 0101 one cycle after the 4th bit
    sendWord(4'b0001, 4'b0100);
    checkOutput("basic_valid", 32'(down_valid), 32'd1);
    checkOutput("basic_data", 32'(down_data), 32'h5);
    checkOutput("basic_any", 32'(down_any), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("basic_cnt", 32'(word_cnt), 32'd1);
    checkOutput("basic_valid_drop", 32'(down_valid), 32'd0);

    // All-zero word, then three all-ones words sent back to back
    sendWord(4'b0000, 4'b0000);
    checkOutput("zero_valid", 32'(down_valid), 32'd1);
    checkOutput("zero_data", 32'(down_data), 32'h0);
    checkOutput("zero_any", 32'(down_any), 32'd0);
    for (int w = 0; w < 3; w++) begin
      sendWord(4'b1111, 4'b0000);
      checkOutput($sformatf("ones%0d_data", w), 32'(down_data), 32'hF);
      checkOutput($sformatf("ones%0d_any", w), 32'(down_any), 32'd1);
      checkOutput($sformatf("ones%0d_cnt", w), 32'(word_cnt), 32'(2 + w));
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ones_cnt", 32'(word_cnt), 32'd5);

    // Backpressure: word 0011 held for 5 cycles with upstream pushing
    down_ready = 1'b0;
    sendWord(4'b0011, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      up_valid = 1'b1;
      a = 1'b1;
      b = 1'b1;
      #1;
      checkOutput($sformatf("bp%0d_upready", c), 32'(up_ready), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("bp%0d_data", c), 32'(down_data), 32'h3);
      checkOutput($sformatf("bp%0d_valid", c), 32'(down_valid), 32'd1);
      checkOutput($sformatf("bp%0d_cnt", c), 32'(word_cnt), 32'd5);
    end
    down_ready = 1'b1;
    up_valid = 1'b1;
    a = 1'b1;
    b = 1'b0;
    #1;
    checkOutput("bp_release_upready", 32'(up_ready), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bp_release_cnt", 32'(word_cnt), 32'd6);
    checkOutput("bp_release_valid", 32'(down_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("bp_next_data", 32'(down_data), 32'h1);
    checkOutput("bp_next_valid", 32'(down_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp_next_cnt", 32'(word_cnt), 32'd7);

    // Bubbles between bits: (0,1) (0,0) (1,0) (1,1) gives 1101
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'bx, 1'bx);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'bx, 1'bx);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("bub_gap_valid", 32'(down_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("bub_data", 32'(down_data), 32'hD);
    checkOutput("bub_valid", 32'(down_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bub_cnt", 32'(word_cnt), 32'd8);

    // Mid-word reset discards the partial word and clears the counter
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("midrst_cnt", 32'(word_cnt), 32'd0);
    checkOutput("midrst_valid", 32'(down_valid), 32'd0);
    sendWord(4'b1000, 4'b0000);
    checkOutput("midrst_data", 32'(down_data), 32'h8);
    checkOutput("midrst_any", 32'(down_any), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midrst_cnt2", 32'(word_cnt), 32'd1);

    // Counter wrap on the narrow instance: 1,2,3,0,1
    doReset();
    for (int w = 0; w < 5; w++) begin
      sendWord(4'b0110, 4'b0000);
      checkOutput($sformatf("wrap%0d_data", w), 32'(nDownData), 32'h6);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("wrap%0d_ncnt", w), 32'(nWordCnt), 32'(wrapExpect[w]));
      checkOutput($sformatf("wrap%0d_cnt", w), 32'(word_cnt), 32'(w + 1));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
